// File: rtl/clock_div_bank_pkg.sv
// ==== clk_div_pkg : shared constants and helpers for the divider bank ====
// ==== rev 1.0 ====
`default_nettype none

package clk_div_pkg;

  localparam int unsigned DIV_DISABLED = 0;
  localparam int unsigned DIV_BYPASS   = 1;
  localparam int unsigned DIV_DEFAULT  = 2;

  // Output stays high while the counter is below this value (floor of D/2).
  function automatic int unsigned high_thresh(input int unsigned d);
    return d / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_div_bank_if.sv
// ==== clock_div_bank_if : configuration and output bundle of the divider bank ====
// ==== rev 1.0 ====
`default_nettype none

interface clock_div_bank_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int CH_W   = 2
) ();

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_half;
  logic              sync_all;
  logic [NUM_CH-1:0] cfg_pending;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] strobe;

  modport master (
    output cfg_we, cfg_ch, cfg_div, cfg_half, sync_all,
    input  cfg_pending, clk_out, strobe
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, cfg_half, sync_all,
    output cfg_pending, clk_out, strobe
  );

endinterface

`default_nettype wire

// File: rtl/clock_div_bank_chan.sv
// ==== clk_div_chan : one programmable divider channel with deferred config ====
// ==== rev 1.0 ====
`default_nettype none

module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = DIV_DEFAULT
) (
  input  wire logic             clk_in,
  input  wire logic             rst,
  input  wire logic             cfg_we,
  input  wire logic [DIV_W-1:0] cfg_div,
  input  wire logic             cfg_half,
  input  wire logic             sync_all,
  output logic                  pending,
  output logic                  clk_out,
  output logic                  strobe
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] cnt;
  logic             half_q;
  logic             pend_half;
  logic             pending_q;
  logic             pos_q;
  logic             neg_q;
  logic             strobe_q;

  logic             wrap;
  logic             apply;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] cnt_next;
  logic             pos_next;
  logic             strobe_next;

  always_comb begin
    wrap        = (cnt == div_q - DIV_W'(1));
    apply       = pending_q && ((div_q == DIV_W'(DIV_DISABLED)) ||
                                (div_q == DIV_W'(DIV_BYPASS)) || wrap || sync_all);
    div_eff     = apply ? pend_div : div_q;
    cnt_next    = '0;
    pos_next    = 1'b0;
    strobe_next = 1'b0;
    if (div_eff == DIV_W'(DIV_DISABLED)) begin
      cnt_next = '0;
    end else if (div_eff == DIV_W'(DIV_BYPASS)) begin
      pos_next    = 1'b1;
      strobe_next = 1'b1;
    end else begin
      // A newly applied divisor always starts a fresh period from zero.
      cnt_next    = (apply || sync_all || wrap) ? '0 : cnt + DIV_W'(1);
      pos_next    = (cnt_next < DIV_W'(high_thresh(32'(div_eff))));
      strobe_next = (cnt_next == '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      div_q     <= DIV_W'(DEFAULT_DIV);
      half_q    <= 1'b0;
      pend_div  <= '0;
      pend_half <= 1'b0;
      pending_q <= 1'b0;
      cnt       <= DIV_W'(DEFAULT_DIV - 1);
      pos_q     <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      if (apply) begin
        div_q  <= pend_div;
        half_q <= pend_half;
      end
      // A write on the apply edge becomes the next pending config.
      if (cfg_we) begin
        pend_div  <= cfg_div;
        pend_half <= cfg_half;
        pending_q <= 1'b1;
      end else if (apply) begin
        pending_q <= 1'b0;
      end
      cnt      <= cnt_next;
      pos_q    <= pos_next;
      strobe_q <= strobe_next;
    end
  end

  always_ff @(negedge clk_in) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= pos_q;
  end

  assign pending = pending_q;
  assign strobe  = strobe_q;
  assign clk_out = pos_q | (half_q & div_q[0] & neg_q);

endmodule

`default_nettype wire

// File: rtl/clock_div_bank.sv
// ==== clock_div_bank : bank of NUM_CH programmable integer clock dividers ====
// ==== rev 1.0 ====
`default_nettype none

module clock_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = DIV_DEFAULT,
  parameter int CH_W        = 2
) (
  input wire logic        clk_in,
  input wire logic        rst,
  clock_div_bank_if.slave bus
);

  logic [NUM_CH-1:0] pend_vec;
  logic [NUM_CH-1:0] clk_vec;
  logic [NUM_CH-1:0] stb_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;

    // Selects at or above NUM_CH match no channel and are dropped.
    assign ch_we = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

    clk_div_chan #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .cfg_we  (ch_we),
      .cfg_div (bus.cfg_div),
      .cfg_half(bus.cfg_half),
      .sync_all(bus.sync_all),
      .pending (pend_vec[i]),
      .clk_out (clk_vec[i]),
      .strobe  (stb_vec[i])
    );
  end

  assign bus.cfg_pending = pend_vec;
  assign bus.clk_out     = clk_vec;
  assign bus.strobe      = stb_vec;

endmodule

`default_nettype wire
